// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and entry type for the fetch queue and PC stage.
package fetch_queue_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          DEPTH_DEF = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array, one synchronous write port, one combinational read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  entry_t           wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output entry_t           rdata_o
);
    entry_t mem_q [DEPTH];

    // Contents are never observed while invalid, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: buffers {Pc, Instr} pairs between fetch and decode with a valid/ready head
// and a count-based FetchEn that stalls the PC stage when full.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      Pc,
    input  logic [31:0]      Instr,
    output logic             FetchEn,
    input  logic             Flush,
    input  logic             D_Ready,
    output logic             D_Valid,
    output logic [31:0]      D_Pc,
    output logic [31:0]      D_Pc8,
    output logic [31:0]      D_Instr,
    output logic             D_AdEL,
    output logic [PTR_W:0]   Count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop;
    entry_t           wr_e, head;

    assign FetchEn = cnt_q != FULL;
    assign D_Valid = cnt_q != '0;
    assign Count   = cnt_q;
    assign push    = FetchEn && !Flush;
    assign pop     = D_Valid && D_Ready && !Flush;
    assign wr_e    = '{pc: Pc, instr: Instr, adel: Pc[1:0] != 2'b00};

    always_comb begin
        wr_d  = Flush ? '0 : wr_q + PTR_W'(push);
        rd_d  = Flush ? '0 : rd_q + PTR_W'(pop);
        cnt_d = Flush ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk_i   (Clk),
        .we_i    (push),
        .waddr_i (wr_q),
        .wdata_i (wr_e),
        .raddr_i (rd_q),
        .rdata_o (head)
    );

    // A misaligned head is presented as a nop carrying the exception flag.
    assign D_Pc    = D_Valid ? head.pc : 32'h0;
    assign D_Pc8   = D_Valid ? head.pc + 32'd8 : 32'h0;
    assign D_AdEL  = D_Valid && head.adel;
    assign D_Instr = (D_Valid && !head.adel) ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus against a queue-based reference model, checked every cycle.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        Clk = 1'b0, Reset = 1'b0, Flush = 1'b0, D_Ready = 1'b0;
    logic [31:0] Pc = '0, Instr = '0;
    logic        FetchEn, D_Valid, D_AdEL;
    logic [31:0] D_Pc, D_Pc8, D_Instr;
    logic [2:0]  Count;
    int          total = 0, bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;
    pair_t q[$];

    fetch_queue dut (
        .Clk(Clk), .Reset(Reset), .Pc(Pc), .Instr(Instr), .FetchEn(FetchEn),
        .Flush(Flush), .D_Ready(D_Ready), .D_Valid(D_Valid), .D_Pc(D_Pc),
        .D_Pc8(D_Pc8), .D_Instr(D_Instr), .D_AdEL(D_AdEL), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most 4 pairs; pop and push decided from pre-edge occupancy.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) q.delete();
        else if (Flush) q.delete();
        else begin
            automatic bit can_push = q.size() < 4;
            if (q.size() > 0 && D_Ready) void'(q.pop_front());
            if (can_push) q.push_back('{pc: Pc, instr: Instr});
        end
    end

    always @(negedge Clk) begin
        automatic bit          v   = q.size() != 0;
        automatic logic [31:0] pc  = v ? q[0].pc : 32'h0;
        automatic bit          mis = v && pc[1:0] != 2'b00;
        chk("m_valid",   32'(D_Valid), 32'(v));
        chk("m_count",   32'(Count),   32'(q.size()));
        chk("m_fetchen", 32'(FetchEn), 32'(q.size() < 4));
        chk("m_pc",      D_Pc,         pc);
        chk("m_pc8",     D_Pc8,        v ? pc + 32'd8 : 32'h0);
        chk("m_instr",   D_Instr,      (v && !mis) ? q[0].instr : NOP_INSTR);
        chk("m_adel",    32'(D_AdEL),  32'(mis));
    end

    task automatic step(input logic [31:0] p, input logic [31:0] i, input logic f, input logic r);
        Pc = p; Instr = i; Flush = f; D_Ready = r;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(D_Valid), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_fetchen", 32'(FetchEn), 32'd1);
        @(posedge Clk); #2;
        Reset = 1'b1;
        // fill to full
        step(RESET_PC,         32'h1111_1111, 0, 0);
        step(RESET_PC + 32'h4, 32'h2222_2222, 0, 0);
        step(RESET_PC + 32'h8, 32'h3333_3333, 0, 0);
        step(RESET_PC + 32'hC, 32'h4444_4444, 0, 0);
        chk("full_count", 32'(Count), 32'd4);
        chk("full_fetchen", 32'(FetchEn), 32'd0);
        chk("full_pc", D_Pc, 32'h3000);
        chk("full_pc8", D_Pc8, 32'h3008);
        chk("full_instr", D_Instr, 32'h1111_1111);
        step(32'h3010, 32'h5555_5555, 0, 0);
        chk("full_hold", 32'(Count), 32'd4);
        step(32'h3010, 32'h5555_5555, 0, 1);
        chk("pop_full_cnt", 32'(Count), 32'd3);
        chk("pop_full_fe", 32'(FetchEn), 32'd1);
        step(0, 0, 1, 0);
        // simultaneous push/pop
        step(32'h3000, 32'hA000_0000, 0, 0);
        step(32'h3004, 32'hA000_0004, 0, 0);
        step(32'h3008, 32'hA000_0008, 0, 1);
        chk("pp_count", 32'(Count), 32'd2);
        chk("pp_pc", D_Pc, 32'h3004);
        step(32'h300C, 32'hA000_000C, 0, 1);
        chk("pp_tail", D_Pc, 32'h3008);
        // flush priority
        step(0, 0, 1, 0);
        step(32'h3000, 32'h1, 0, 0);
        step(32'h3004, 32'h2, 0, 0);
        step(32'h3008, 32'h3, 0, 0);
        chk("fl_pre", 32'(Count), 32'd3);
        step(32'h300C, 32'h4, 1, 1);
        chk("fl_count", 32'(Count), 32'd0);
        chk("fl_valid", 32'(D_Valid), 32'd0);
        chk("fl_instr", D_Instr, 32'h0);
        step(32'h3400, 32'h0BAD_F00D, 0, 0);
        chk("fl_head", D_Pc, 32'h3400);
        step(0, 0, 1, 0);
        // empty with ready: first pushes, never pops an empty queue
        for (int i = 0; i < 10; i++) begin
            step(RESET_PC + 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 1);
            chk("wrap_pc", D_Pc, RESET_PC + 32'(4 * i));
            chk("wrap_cnt", 32'(Count), 32'd1);
        end
        step(0, 0, 1, 0);
        // misalignment
        step(32'h3002, 32'hDEAD_BEEF, 0, 0);
        chk("mis_adel", 32'(D_AdEL), 32'd1);
        chk("mis_instr", D_Instr, 32'h0);
        chk("mis_pc", D_Pc, 32'h3002);
        step(32'h3004, 32'h1234_5678, 0, 1);
        chk("al_adel", 32'(D_AdEL), 32'd0);
        chk("al_instr", D_Instr, 32'h1234_5678);
        step(0, 0, 1, 0);
        // reset mid-stream
        step(32'h3000, 32'h1, 0, 0);
        step(32'h3004, 32'h2, 0, 0);
        step(32'h3008, 32'h3, 0, 0);
        chk("mr_pre", 32'(Count), 32'd3);
        #1 Reset = 1'b0;
        #1;
        chk("mr_valid", 32'(D_Valid), 32'd0);
        chk("mr_count", 32'(Count), 32'd0);
        chk("mr_fetchen", 32'(FetchEn), 32'd1);
        @(posedge Clk); #2;
        Reset = 1'b1;
        step(RESET_PC, 32'h7777_7777, 0, 0);
        chk("mr_push_pc", D_Pc, RESET_PC);
        chk("mr_push_cnt", 32'(Count), 32'd1);
        step(0, 0, 1, 0);
        @(negedge Clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the PC register / instruction memory and the decode stage of the P5 pipeline.
- Each cycle it captures the current fetch address and the instruction word read at that address into a small FIFO.
- It presents the oldest entry to decode through a valid/ready handshake.
- It tells the PC stage when to advance, and discards all buffered entries on a redirect (branch/jump flush).

Parameters:
DEPTH, 4, number of buffered {Pc, Instr} entries; power of two, at least 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Pc  in  32  current fetch address from the PC register
Instr  in  32  IM word at Pc (combinational ROM output, valid in the same cycle)
FetchEn  out  1  queue accepts the {Pc, Instr} pair this cycle; PC stage loads NPC only when 1, otherwise holds
Flush  in  1  redirect from branch/jump resolution; synchronous clear
D_Ready  in  1  decode can take the head entry this cycle
D_Valid  out  1  head entry present
D_Pc  out  32  PC of the head entry
D_Pc8  out  32  D_Pc + 8 (link address for jal/jalr)
D_Instr  out  32  instruction of the head entry
D_AdEL  out  1  head entry was fetched from a misaligned Pc
Count  out  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- State: storage array, wr_ptr and rd_ptr (PTR_W bits each, natural wrap), and count (PTR_W+1 bits).
- Reset low, asynchronous, takes effect immediately without a clock edge:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Hence D_Valid=0, Count=0, FetchEn=1.
  - Storage contents are don't-care.
- FetchEn = (count != DEPTH). It is purely count-based and has no combinational path from D_Ready.
- push = FetchEn && !Flush. On the rising edge, store {Pc, Instr, Pc[1:0]!=0} at wr_ptr and increment wr_ptr.
- pop = D_Valid && D_Ready && !Flush. On the rising edge, increment rd_ptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; head advances and tail advances.
- Flush has highest priority. On that edge, wr_ptr = rd_ptr = 0 and count = 0. The current pair is not stored and the head is not consumed, even if D_Ready=1.
- Latency: an entry pushed at edge N is visible on D_* after edge N. There is no empty-bypass path.
- D_Valid = (count != 0).
- D_* outputs when D_Valid=1:
  - Driven from the entry at rd_ptr.
  - D_Pc8 = D_Pc + 8, modulo 2^32.
- D_* outputs when D_Valid=0:
  - D_Instr = 32'h0000_0000 (nop).
  - D_Pc = 0, D_Pc8 = 0, D_AdEL = 0.
- Misaligned entry: D_AdEL=1 and D_Instr is forced to 0, so decode sees a nop carrying the exception flag. D_Pc still shows the raw misaligned address.
- Full: FetchEn=0 and the PC stage holds. A pop at full frees a slot, and FetchEn rises the next cycle.
- Empty with D_Ready=1: no pop and no state change.
- Reset asserted mid-stream: all entries are lost immediately, regardless of Flush or handshake state.
- Outputs are never X after reset release.

Decomposition:
- Shared package:
  - NOP_INSTR = 32'h0000_0000.
  - RESET_PC = 32'h0000_3000 (used by the PC stage and the bench).
  - Entry typedef {pc[31:0], instr[31:0], adel}.
  - Default DEPTH.
- Sub-module fetch_queue_mem: the DEPTH-entry register array with one synchronous write port and one combinational read port.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset mid-operation: Count=3, drive Reset=0 between clock edges -> D_Valid=0, Count=0, FetchEn=1 before the next edge. After release, the first push of Pc=0x3000 appears after one edge.
- Fill to full: D_Ready=0, present Pc 0x3000/0x3004/0x3008/0x300C with Instr 0x11111111..0x44444444 -> after 4 edges Count=4 and FetchEn=0. Pc 0x3010 is not stored. D_Pc=0x3000, D_Pc8=0x3008, D_Instr=0x11111111.
- Simultaneous push/pop: Count=2, D_Ready=1, Pc=0x3008 -> after the edge Count=2, D_Pc advances from 0x3000 to 0x3004, and 0x3008 sits at the tail.
- Flush priority: Count=3, Flush=1, D_Ready=1, FetchEn=1 -> after the edge Count=0, D_Valid=0, D_Instr=0. The next push, Pc=0x3400, becomes the head.
- Wrap-around: stream 10 sequential Pcs from 0x3000 with D_Ready=1 continuously -> decode receives 0x3000..0x3024 in order with no gaps after the first cycle. D_Pc8 = D_Pc+8 throughout, and pointers wrap twice.
- Misalignment: push Pc=0x3002, Instr=0xDEADBEEF -> head shows D_AdEL=1, D_Instr=0, D_Pc=0x3002. The next aligned entry shows D_AdEL=0.
